// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer slice.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_seq_state_t;

  localparam int RETRY_W = 4;

  // Largest of three cycle counts; sizes the single shared interval counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
interface pll_seq_if;
  import pll_seq_pkg::*;

  logic               locked;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               fail;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_cnt;

  // Sequencer side: observes the PLL and software request, drives resets/status.
  modport master (
    input  locked, relock_req,
    output pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt
  );

  // Surrounding side: supplies lock and requests, consumes resets/status.
  modport slave (
    output locked, relock_req,
    input  pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt
  );

endinterface

// File: rtl/pll_reset_sequencer_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset to zero.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises PLL start-up: timed PLL reset, lock wait with bounded retries,
// lock stability qualification, and downstream reset release / re-sequencing.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic        refclk,
  input  logic        rst,
  pll_seq_if.master   bus
);

  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

  pll_seq_state_t     state_r;
  pll_seq_state_t     state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [RETRY_W-1:0] retry_r;
  logic [RETRY_W-1:0] retry_nxt_s;
  logic               lock_lost_r;
  logic               lock_lost_nxt_s;
  logic               lock_s;
  logic               lost_in_run_s;
  logic               pll_rst_r;
  logic               sys_rst_r;
  logic               ready_r;
  logic               fail_r;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.locked),
    .q   (lock_s)
  );

  assign lost_in_run_s = (state_r == RUN) && !lock_s;

  // Next-state, interval counter, retry count and sticky lock-loss decisions
  always_comb begin
    state_nxt_s     = state_r;
    retry_nxt_s     = retry_r;
    lock_lost_nxt_s = lock_lost_r;
    cnt_nxt_s       = '0;
    if (bus.relock_req) begin
      // A software request overrides every other event; a coincident lock
      // loss in RUN still leaves the sticky flag set.
      state_nxt_s     = PLL_RST;
      retry_nxt_s     = '0;
      lock_lost_nxt_s = lost_in_run_s;
    end else begin
      case (state_r)
        PLL_RST: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = WAIT_LOCK;
          end else begin
            state_nxt_s = PLL_RST;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt_s = STABLE;
          end else if (cnt_r == TO_LAST) begin
            if (retry_r == RETRY_MAX) begin
              state_nxt_s = FAIL;
            end else begin
              state_nxt_s = PLL_RST;
              retry_nxt_s = retry_r + RETRY_ONE;
            end
          end else begin
            state_nxt_s = WAIT_LOCK;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            // A dropout while qualifying is not a timeout; just wait again.
            state_nxt_s = WAIT_LOCK;
          end else if (cnt_r == STABLE_LAST) begin
            state_nxt_s = RUN;
            retry_nxt_s = '0;
          end else begin
            state_nxt_s = STABLE;
          end
        end
        RUN: begin
          if (lost_in_run_s) begin
            state_nxt_s     = PLL_RST;
            lock_lost_nxt_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        FAIL: begin
          state_nxt_s = FAIL;
        end
        default: begin
          state_nxt_s = PLL_RST;
        end
      endcase
    end
    // The counter restarts on every transition and on any relock request.
    if (bus.relock_req || (state_nxt_s != state_r)) begin
      cnt_nxt_s = '0;
    end else if ((state_r == RUN) || (state_r == FAIL)) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // State, counter, retry and sticky-flag registers
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r     <= PLL_RST;
      cnt_r       <= '0;
      retry_r     <= '0;
      lock_lost_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      retry_r     <= retry_nxt_s;
      lock_lost_r <= lock_lost_nxt_s;
    end
  end

  // Registered output decode so outputs change on the edge entering a state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_r <= 1'b1;
      sys_rst_r <= 1'b1;
      ready_r   <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      pll_rst_r <= (state_nxt_s == PLL_RST) || (state_nxt_s == FAIL);
      sys_rst_r <= (state_nxt_s != RUN);
      ready_r   <= (state_nxt_s == RUN);
      fail_r    <= (state_nxt_s == FAIL);
    end
  end

  assign bus.pll_rst   = pll_rst_r;
  assign bus.sys_rst   = sys_rst_r;
  assign bus.ready     = ready_r;
  assign bus.fail      = fail_r;
  assign bus.lock_lost = lock_lost_r;
  assign bus.retry_cnt = retry_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small cycle parameters.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int RST_C  = 4;
  localparam int TO_C   = 20;
  localparam int ST_C   = 8;
  localparam int MAX_R  = 2;
  localparam int PERIOD = RST_C + TO_C;  // length of one failed attempt

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  pll_seq_if bus();

  pll_reset_sequencer #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (ST_C),
    .MAX_RETRIES   (MAX_R)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  // Edge counter: after an edge, cyc holds that edge's index
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic pulse_relock(output int r_edge);
    bus.relock_req = 1'b1;
    tick();
    r_edge = cyc;
    bus.relock_req = 1'b0;
  endtask

  // Number of consecutive samples (starting now) with pll_rst high
  task automatic count_pll_rst(output int n);
    n = 0;
    while (bus.pll_rst === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  // Edge at which ready first rises (-1 if not within budget) and retry_cnt just before
  task automatic wait_ready(input int budget, output int r_edge, output logic [3:0] retry_before);
    r_edge = -1;
    retry_before = 4'hF;
    for (int i = 0; i < budget; i++) begin
      retry_before = bus.retry_cnt;
      tick();
      if (bus.ready === 1'b1) begin
        r_edge = cyc;
        break;
      end
    end
  endtask

  // Reference: given PLL_RST entry edge r and first edge el sampling locked=1
  // (held high), predict RUN entry edge or FAIL entry edge and the retry count.
  function automatic void model(input int r, input int el, output bit is_fail,
                                output int ev, output int retries);
    int w;
    is_fail = 1'b0;
    ev = -1;
    retries = 0;
    for (int a = 0; a <= MAX_R; a++) begin
      w = r + RST_C + a * PERIOD;  // WAIT_LOCK entry of attempt a
      if (el + 2 <= w + TO_C) begin
        ev = ((el + 2 > w + 1) ? el + 2 : w + 1) + ST_C;
        retries = a;
        return;
      end
    end
    is_fail = 1'b1;
    ev = r + (MAX_R + 1) * PERIOD;
    retries = MAX_R;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.locked = 1'b0;
    bus.relock_req = 1'b0;
    repeat (3) tick();
    n_total++; if (bus.pll_rst !== 1'b1) $display("FAIL reset_pll_rst got %b want 1", bus.pll_rst); else n_pass++;
    n_total++; if (bus.sys_rst !== 1'b1) $display("FAIL reset_sys_rst got %b want 1", bus.sys_rst); else n_pass++;
    n_total++; if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready); else n_pass++;
    n_total++; if (bus.fail !== 1'b0) $display("FAIL reset_fail got %b want 0", bus.fail); else n_pass++;
    n_total++; if (bus.lock_lost !== 1'b0) $display("FAIL reset_lock_lost got %b want 0", bus.lock_lost); else n_pass++;
    n_total++; if (bus.retry_cnt !== 4'd0) $display("FAIL reset_retry got %0d want 0", bus.retry_cnt); else n_pass++;
  endtask

  task automatic test_normal_start();
    int n, e0, got;
    logic [3:0] rb;
    rst = 1'b0;
    count_pll_rst(n);
    n_total++; if (n != RST_C) $display("FAIL start_pll_rst_len got %0d want %0d", n, RST_C); else n_pass++;
    repeat (5) tick();
    bus.locked = 1'b1;
    e0 = cyc + 1;
    wait_ready(40, got, rb);
    n_total++; if (got != e0 + ST_C + 2) $display("FAIL start_ready_edge got %0d want %0d", got, e0 + ST_C + 2); else n_pass++;
    n_total++; if (bus.sys_rst !== 1'b0) $display("FAIL start_sys_rst got %b want 0", bus.sys_rst); else n_pass++;
    n_total++; if (bus.retry_cnt !== 4'd0) $display("FAIL start_retry got %0d want 0", bus.retry_cnt); else n_pass++;
  endtask

  task automatic test_lock_loss();
    int e0, r, el, got;
    logic [3:0] rb;
    bus.locked = 1'b0;
    e0 = cyc + 1;
    tick();
    tick();
    n_total++; if (bus.sys_rst !== 1'b0) $display("FAIL loss_sys_rst_early got %b want 0", bus.sys_rst); else n_pass++;
    tick();
    n_total++; if (bus.sys_rst !== 1'b1) $display("FAIL loss_sys_rst got %b want 1", bus.sys_rst); else n_pass++;
    n_total++; if (bus.lock_lost !== 1'b1) $display("FAIL loss_lock_lost got %b want 1", bus.lock_lost); else n_pass++;
    n_total++; if (bus.pll_rst !== 1'b1) $display("FAIL loss_pll_rst got %b want 1", bus.pll_rst); else n_pass++;
    n_total++; if (bus.ready !== 1'b0) $display("FAIL loss_ready got %b want 0", bus.ready); else n_pass++;
    r = e0 + 2;
    el = r + RST_C + int'($urandom_range(0, 15));
    while (cyc < el - 1) tick();
    bus.locked = 1'b1;
    wait_ready(60, got, rb);
    n_total++; if (got != el + ST_C + 2) $display("FAIL loss_relock_edge got %0d want %0d", got, el + ST_C + 2); else n_pass++;
    n_total++; if (bus.lock_lost !== 1'b1) $display("FAIL loss_sticky got %b want 1", bus.lock_lost); else n_pass++;
  endtask

  task automatic test_simultaneous_loss();
    int r, got, ev, rt;
    bit f;
    logic [3:0] rb;
    pulse_relock(r);
    n_total++; if (bus.lock_lost !== 1'b0) $display("FAIL simul_relock_clear got %b want 0", bus.lock_lost); else n_pass++;
    model(r, r, f, ev, rt);
    wait_ready(40, got, rb);
    n_total++; if (got != ev) $display("FAIL simul_rerun_edge got %0d want %0d", got, ev); else n_pass++;
    bus.locked = 1'b0;
    tick();
    tick();
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    n_total++; if (bus.pll_rst !== 1'b1) $display("FAIL simul_pll_rst got %b want 1", bus.pll_rst); else n_pass++;
    n_total++; if (bus.lock_lost !== 1'b1) $display("FAIL simul_lock_lost got %b want 1", bus.lock_lost); else n_pass++;
    n_total++; if (bus.ready !== 1'b0) $display("FAIL simul_ready got %b want 0", bus.ready); else n_pass++;
  endtask

  task automatic test_timeouts_to_fail();
    int r, e1, e2, ef, bad, n;
    pulse_relock(r);
    n_total++; if (bus.lock_lost !== 1'b0) $display("FAIL fail_relock_clear got %b want 0", bus.lock_lost); else n_pass++;
    e1 = -1; e2 = -1; ef = -1;
    for (int i = 0; i < 150 && ef < 0; i++) begin
      tick();
      if (e1 < 0 && bus.retry_cnt === 4'd1) e1 = cyc;
      if (e2 < 0 && bus.retry_cnt === 4'd2) e2 = cyc;
      if (bus.fail === 1'b1) ef = cyc;
    end
    n_total++; if (e1 != r + PERIOD) $display("FAIL fail_retry1_edge got %0d want %0d", e1, r + PERIOD); else n_pass++;
    n_total++; if (e2 != r + 2 * PERIOD) $display("FAIL fail_retry2_edge got %0d want %0d", e2, r + 2 * PERIOD); else n_pass++;
    n_total++; if (ef != r + 3 * PERIOD) $display("FAIL fail_entry_edge got %0d want %0d", ef, r + 3 * PERIOD); else n_pass++;
    bad = 0;
    for (int i = 0; i < 110; i++) begin
      if (!(bus.fail === 1'b1 && bus.pll_rst === 1'b1 && bus.sys_rst === 1'b1 && bus.retry_cnt === 4'd2)) bad++;
      tick();
    end
    n_total++; if (bad != 0) $display("FAIL fail_hold got %0d bad cycles want 0", bad); else n_pass++;
    pulse_relock(r);
    n_total++; if (bus.fail !== 1'b0) $display("FAIL fail_exit got %b want 0", bus.fail); else n_pass++;
    n_total++; if (bus.retry_cnt !== 4'd0) $display("FAIL fail_exit_retry got %0d want 0", bus.retry_cnt); else n_pass++;
    count_pll_rst(n);
    n_total++; if (n != RST_C) $display("FAIL fail_exit_pll_rst_len got %0d want %0d", n, RST_C); else n_pass++;
  endtask

  task automatic test_glitch();
    int r, e0, e1, got;
    logic [3:0] rb;
    pulse_relock(r);
    e0 = r + RST_C + int'($urandom_range(0, 8));
    while (cyc < e0 - 1) tick();
    bus.locked = 1'b1;
    repeat (5) tick();
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    e1 = cyc + 1;
    wait_ready(60, got, rb);
    n_total++; if (got != e1 + ST_C + 2) $display("FAIL glitch_ready_edge got %0d want %0d", got, e1 + ST_C + 2); else n_pass++;
    n_total++; if (rb !== 4'd0) $display("FAIL glitch_retry got %0d want 0", rb); else n_pass++;
  endtask

  task automatic test_relock_on_timeout();
    int r, t;
    bus.locked = 1'b0;
    pulse_relock(r);
    t = r + PERIOD;
    while (cyc < t - 1) tick();
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    n_total++; if (bus.retry_cnt !== 4'd0) $display("FAIL to_relock_retry got %0d want 0", bus.retry_cnt); else n_pass++;
    n_total++; if (bus.pll_rst !== 1'b1) $display("FAIL to_relock_pll_rst got %b want 1", bus.pll_rst); else n_pass++;
    while (cyc < t + PERIOD - 1) tick();
    n_total++; if (bus.retry_cnt !== 4'd0) $display("FAIL to_relock_pre got %0d want 0", bus.retry_cnt); else n_pass++;
    tick();
    n_total++; if (bus.retry_cnt !== 4'd1) $display("FAIL to_relock_next got %0d want 1", bus.retry_cnt); else n_pass++;
    n_total++; if (bus.fail !== 1'b0) $display("FAIL to_relock_fail got %b want 0", bus.fail); else n_pass++;
  endtask

  task automatic test_random();
    int r, j, el, ev, rt, got;
    bit f;
    logic [3:0] rb;
    for (int it = 0; it < 6; it++) begin
      bus.locked = 1'b0;
      pulse_relock(r);
      j = int'($urandom_range(0, MAX_R + 1));
      el = r + RST_C + j * PERIOD + int'($urandom_range(0, 18));
      model(r, el, f, ev, rt);
      if (!f) begin
        while (cyc < el - 1) tick();
        bus.locked = 1'b1;
        wait_ready(120, got, rb);
        n_total++; if (got != ev) $display("FAIL rand%0d_ready_edge got %0d want %0d", it, got, ev); else n_pass++;
        n_total++; if (rb !== 4'(rt)) $display("FAIL rand%0d_retry got %0d want %0d", it, rb, rt); else n_pass++;
      end else begin
        got = -1;
        for (int i = 0; i < 120 && got < 0; i++) begin
          tick();
          if (bus.fail === 1'b1) got = cyc;
        end
        n_total++; if (got != ev) $display("FAIL rand%0d_fail_edge got %0d want %0d", it, got, ev); else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    int r, el, n;
    bus.locked = 1'b0;
    pulse_relock(r);
    el = r + RST_C + PERIOD + 1;
    while (cyc < el - 1) tick();
    bus.locked = 1'b1;
    while (cyc < el + 4) tick();
    n_total++; if (bus.retry_cnt !== 4'd1) $display("FAIL arst_pre_retry got %0d want 1", bus.retry_cnt); else n_pass++;
    n_total++; if (bus.pll_rst !== 1'b0) $display("FAIL arst_pre_pll_rst got %b want 0", bus.pll_rst); else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_total++; if (bus.pll_rst !== 1'b1) $display("FAIL arst_pll_rst got %b want 1", bus.pll_rst); else n_pass++;
    n_total++; if (bus.sys_rst !== 1'b1) $display("FAIL arst_sys_rst got %b want 1", bus.sys_rst); else n_pass++;
    n_total++; if (bus.retry_cnt !== 4'd0) $display("FAIL arst_retry got %0d want 0", bus.retry_cnt); else n_pass++;
    n_total++; if (bus.ready !== 1'b0 || bus.fail !== 1'b0 || bus.lock_lost !== 1'b0)
      $display("FAIL arst_status got ready=%b fail=%b lost=%b want 000", bus.ready, bus.fail, bus.lock_lost); else n_pass++;
    tick();
    rst = 1'b0;
    count_pll_rst(n);
    n_total++; if (n != RST_C) $display("FAIL arst_pll_rst_len got %0d want %0d", n, RST_C); else n_pass++;
  endtask

  initial begin
    bus.locked = 1'b0;
    bus.relock_req = 1'b0;
    test_reset();
    test_normal_start();
    test_lock_loss();
    test_simultaneous_loss();
    test_timeouts_to_fail();
    test_glitch();
    test_relock_on_timeout();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
